// File: rtl/lights_off_pkg.sv
// Shared types and constants for the lights-off puzzle: FSM state encoding, LFSR
// parameters and the neighbourhood mask helper.
package lights_off_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StWon  = 2'd2
  } game_state_e;

  localparam logic [31:0] LfsrSeed = 32'hACE12468;
  // Taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0).
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  // Bits i-radius..i+radius of an n-wide row; out-of-row indices dropped or wrapped.
  function automatic logic [31:0] nbr_mask(input int i, input int n, input int radius,
                                           input bit wrap);
    logic [31:0] m;
    m = '0;
    for (int d = -radius; d <= radius; d++) begin
      int j;
      j = i + d;
      if (wrap) j = (j + n) % n;
      if (j >= 0 && j < n) m[j] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit stability filter; emits a one-cycle pulse on each
// accepted change (or only on 1->0 changes when FALL_ONLY is set).
module sw_debounce #(
  parameter int unsigned      WIDTH      = 1,
  parameter int unsigned      DEB_CYCLES = 2,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter bit               FALL_ONLY  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pulse
);

  localparam int unsigned     CntW   = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        // The cycle with cnt at CntMax is the DEB_CYCLES-th consecutive differing cycle.
        if (cnt_q[i] == CntMax) filt_d[i] = sync2_q[i];
        else                    cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    pulse_d = filt_d ^ filt_q;
    if (FALL_ONLY) pulse_d = pulse_d & ~filt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      filt_q  <= RST_VAL;
      pulse_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/lights_off_game.sv
// Parametrised single-row lights-off game: conditioned inputs, LFSR scramble, fixed load,
// saturating move counter and win FSM. Optional undo when LIGHTS_OFF_UNDO_EN is defined.
module lights_off_game
  import lights_off_pkg::*;
#(
  parameter int unsigned  N           = 10,
  parameter int unsigned  RADIUS      = 1,
  parameter int unsigned  WRAP        = 0,
  parameter int unsigned  DEB_CYCLES  = 500000,
  parameter logic [N-1:0] FIX_PATTERN = N'(10'b0111111110),
  parameter int unsigned  MOVE_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      sw,
  input  logic              btn_fix_n,
  input  logic              btn_rand_n,
`ifdef LIGHTS_OFF_UNDO_EN
  input  logic              btn_undo_n,
`endif
  output logic [N-1:0]      lights,
  output logic [MOVE_W-1:0] moves,
  output logic              won,
  output logic [1:0]        state
);

`ifdef LIGHTS_OFF_UNDO_EN
  localparam int unsigned NBtn = 3;
  logic [NBtn-1:0] btn_raw;
  assign btn_raw = {btn_undo_n, btn_rand_n, btn_fix_n};
`else
  localparam int unsigned NBtn = 2;
  logic [NBtn-1:0] btn_raw;
  assign btn_raw = {btn_rand_n, btn_fix_n};
`endif

  logic [N-1:0]    sw_evt;
  logic [NBtn-1:0] btn_press;
  logic            fix_press, rand_press;

  sw_debounce #(
    .WIDTH     (N),
    .DEB_CYCLES(DEB_CYCLES),
    .RST_VAL   ({N{1'b0}}),
    .FALL_ONLY (1'b0)
  ) u_sw_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (sw),
    .pulse(sw_evt)
  );

  sw_debounce #(
    .WIDTH     (NBtn),
    .DEB_CYCLES(DEB_CYCLES),
    .RST_VAL   ({NBtn{1'b1}}),
    .FALL_ONLY (1'b1)
  ) u_btn_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_raw),
    .pulse(btn_press)
  );

  assign fix_press  = btn_press[0];
  assign rand_press = btn_press[1];

  logic [N-1:0] mask_tab [N];
  for (genvar g = 0; g < N; g++) begin : g_mask
    localparam logic [31:0] MaskFull = nbr_mask(g, N, RADIUS, WRAP != 0);
    assign mask_tab[g] = MaskFull[N-1:0];
  end

  game_state_e       state_q, state_d;
  logic [N-1:0]      lights_q, lights_d;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic [31:0]       lfsr_q;
  logic [N-1:0]      move_mask, scr_mask;

`ifdef LIGHTS_OFF_UNDO_EN
  logic         undo_press;
  logic [N-1:0] hist_q, hist_d;
  logic         hist_vld_q, hist_vld_d;
  assign undo_press = btn_press[2];
`endif

  always_comb begin
    move_mask = '0;
    scr_mask  = '0;
    for (int i = 0; i < N; i++) begin
      if (sw_evt[i]) move_mask = move_mask ^ mask_tab[i];
      if (lfsr_q[i]) scr_mask  = scr_mask ^ mask_tab[i];
    end
    // An empty scramble would be an instant win; fall back to a single-switch board.
    if (scr_mask == '0) scr_mask = mask_tab[0];
  end

  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    moves_d  = moves_q;
`ifdef LIGHTS_OFF_UNDO_EN
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
`endif
    if (rand_press || fix_press) begin
      lights_d = rand_press ? scr_mask : FIX_PATTERN;
      moves_d  = '0;
      state_d  = StPlay;
`ifdef LIGHTS_OFF_UNDO_EN
      hist_vld_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StPlay: begin
          if (lights_q == '0) begin
            state_d = StWon;
`ifdef LIGHTS_OFF_UNDO_EN
          end else if (undo_press) begin
            if (hist_vld_q) begin
              lights_d   = lights_q ^ hist_q;
              hist_vld_d = 1'b0;
              if (moves_q != '0) moves_d = moves_q - 1'b1;
            end
`endif
          end else if (sw_evt != '0) begin
            lights_d = lights_q ^ move_mask;
            if (moves_q != '1) moves_d = moves_q + 1'b1;
`ifdef LIGHTS_OFF_UNDO_EN
            hist_d     = move_mask;
            hist_vld_d = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lights_q <= '0;
      moves_q  <= '0;
      lfsr_q   <= LfsrSeed;
`ifdef LIGHTS_OFF_UNDO_EN
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      moves_q  <= moves_d;
      lfsr_q   <= {lfsr_q[30:0], ^(lfsr_q & LfsrTaps)};
`ifdef LIGHTS_OFF_UNDO_EN
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
`endif
    end
  end

  assign lights = lights_q;
  assign moves  = moves_q;
  assign won    = (state_q == StWon);
  assign state  = state_q;

endmodule

// File: tb/tb_lights_off_game.sv
// Scoreboard bench: stimulus pushes expected output changes, the monitor pops one per
// observed change of {lights, moves, won, state} and checks value and arrival cycle.
module tb_lights_off_game;

  localparam logic [1:0] SIdle = 2'd0, SPlay = 2'd1, SWon = 2'd2;
  localparam logic [9:0] Fix   = 10'b0111111110;

  logic       clk, rst;
  logic [9:0] sw_a, sw_b;
  logic       btn_fix_a, btn_rand_a, btn_fix_b, btn_rand_b;
  logic [9:0] lights_a, lights_b;
  logic [15:0] moves_a;
  logic [1:0]  moves_b;
  logic        won_a, won_b;
  logic [1:0]  state_a, state_b;

  lights_off_game #(
    .N(10), .RADIUS(1), .WRAP(0), .DEB_CYCLES(4), .FIX_PATTERN(Fix), .MOVE_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .sw(sw_a), .btn_fix_n(btn_fix_a), .btn_rand_n(btn_rand_a),
`ifdef LIGHTS_OFF_UNDO_EN
    .btn_undo_n(1'b1),
`endif
    .lights(lights_a), .moves(moves_a), .won(won_a), .state(state_a)
  );

  lights_off_game #(
    .N(10), .RADIUS(1), .WRAP(1), .DEB_CYCLES(4), .FIX_PATTERN(Fix), .MOVE_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .sw(sw_b), .btn_fix_n(btn_fix_b), .btn_rand_n(btn_rand_b),
`ifdef LIGHTS_OFF_UNDO_EN
    .btn_undo_n(1'b1),
`endif
    .lights(lights_b), .moves(moves_b), .won(won_b), .state(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, ncyc = 0;
  bit mon_en = 1'b0;
  logic [31:0] m_lfsr;
  logic [31:0] prev_a, prev_b, cur_a, cur_b;
  logic [31:0] qa_val[$], qb_val[$];
  int          qa_due[$], qb_due[$];
  string       qa_nm[$],  qb_nm[$];

  function automatic logic [31:0] step(input logic [31:0] q);
    return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
  endfunction

  function automatic logic [31:0] step_n(input logic [31:0] q, input int n);
    logic [31:0] r;
    r = q;
    for (int k = 0; k < n; k++) r = step(r);
    return r;
  endfunction

  function automatic logic [9:0] ref_mask(input int i, input bit wrap);
    logic [9:0] m;
    m = '0;
    for (int j = 0; j < 10; j++) begin
      int d;
      d = (j > i) ? j - i : i - j;
      if (wrap && (10 - d) < d) d = 10 - d;
      if (d <= 1) m[j] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [9:0] ref_scramble(input logic [31:0] x);
    logic [9:0] acc;
    acc = '0;
    for (int i = 0; i < 10; i++) if (x[i]) acc = acc ^ ref_mask(i, 1'b0);
    if (acc == '0) acc = ref_mask(0, 1'b0);
    return acc;
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= 32'hACE12468;
    else     m_lfsr <= step(m_lfsr);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %h, expected no event", nm, act);
  endtask

  task automatic exp_a(input logic [9:0] l, input int mv, input bit w, input logic [1:0] st,
                       input int lat, input string nm);
    qa_val.push_back({3'b0, l, 16'(mv), w, st});
    qa_due.push_back(ncyc + lat);
    qa_nm.push_back(nm);
  endtask

  task automatic exp_b(input logic [9:0] l, input int mv, input logic [1:0] st,
                       input string nm);
    qb_val.push_back({3'b0, l, 14'b0, 2'(mv), 1'b0, st});
    qb_due.push_back(ncyc + 7);
    qb_nm.push_back(nm);
  endtask

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    cur_a = {3'b0, lights_a, moves_a, won_a, state_a};
    cur_b = {3'b0, lights_b, 14'b0, moves_b, won_b, state_b};
    if (mon_en) begin
      if (cur_a !== prev_a) begin
        if (qa_val.size() == 0) flag("unexpected change A", cur_a);
        else begin
          check(qa_nm[0], cur_a, qa_val[0]);
          check({qa_nm[0], " cycle"}, ncyc, qa_due[0]);
          void'(qa_val.pop_front());
          void'(qa_due.pop_front());
          void'(qa_nm.pop_front());
        end
      end
      if (cur_b !== prev_b) begin
        if (qb_val.size() == 0) flag("unexpected change B", cur_b);
        else begin
          check(qb_nm[0], cur_b, qb_val[0]);
          check({qb_nm[0], " cycle"}, ncyc, qb_due[0]);
          void'(qb_val.pop_front());
          void'(qb_due.pop_front());
          void'(qb_nm.pop_front());
        end
      end
    end
    prev_a = cur_a;
    prev_b = cur_b;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic fix_a(input string nm);
    btn_fix_a = 1'b0;
    exp_a(Fix, 0, 1'b0, SPlay, 7, nm);
    tick(10);
    btn_fix_a = 1'b1;
    tick(10);
  endtask

  task automatic tog_a(input logic [9:0] bits, input logic [9:0] l, input int mv,
                       input string nm);
    sw_a = sw_a ^ bits;
    exp_a(l, mv, 1'b0, SPlay, 7, nm);
    tick(10);
  endtask

  initial begin
    logic [31:0] x;
    logic [9:0]  l;
    bit          found;
    rst = 1'b1; sw_a = '0; sw_b = '0;
    btn_fix_a = 1'b1; btn_rand_a = 1'b1; btn_fix_b = 1'b1; btn_rand_b = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(2);
    check("reset A", {3'b0, lights_a, moves_a, won_a, state_a}, 32'd0);
    check("reset B", {3'b0, lights_b, 14'b0, moves_b, won_b, state_b}, 32'd0);
    mon_en = 1'b1;
    tick(1);

    // Basic moves at both row ends.
    fix_a("fix1");
    tog_a(10'b0000000001, 10'b0111111101, 1, "move sw0");
    tog_a(10'b1000000000, 10'b1011111101, 2, "move sw9");

    // Short bounce is filtered, a held change is accepted.
    fix_a("fix2");
    sw_a[3] = 1'b1;
    tick(3);
    sw_a[3] = 1'b0;
    tick(10);
    tog_a(10'b0000001000, 10'b0111100010, 1, "move sw3 held");

    // Solve in two simultaneous groups, then the win and ignored moves.
    fix_a("fix3");
    tog_a(10'b0000011111, 10'b0111010000, 1, "group low");
    sw_a = sw_a ^ 10'b1111100000;
    exp_a(10'b0000000000, 2, 1'b0, SPlay, 7, "group high");
    exp_a(10'b0000000000, 2, 1'b1, SWon, 8, "win");
    tick(12);
    sw_a = sw_a ^ 10'b0000000010;
    tick(12);

    // Time a rand press onto an LFSR state whose low 10 bits are zero.
    found = 1'b0;
    for (int k = 0; k < 60000 && !found; k++) begin
      x = step_n(m_lfsr, 6);
      if (x[9:0] == 10'd0) found = 1'b1;
      else tick(1);
    end
    if (!found) flag("rand zero search timeout", x);
    btn_rand_a = 1'b0;
    if (found) exp_a(10'b0000000011, 0, 1'b0, SPlay, 7, "rand zero");
    tick(10);
    btn_rand_a = 1'b1;
    tick(10);
    tog_a(10'b0000100000, 10'b0001110011, 1, "move sw5");

    // Rand and fix together: rand wins.
    x = step_n(m_lfsr, 6);
    l = ref_scramble(x);
    btn_rand_a = 1'b0;
    btn_fix_a  = 1'b0;
    exp_a(l, 0, 1'b0, SPlay, 7, "rand+fix");
    tick(10);
    btn_rand_a = 1'b1;
    btn_fix_a  = 1'b1;
    tick(10);
    for (int i = 0; i < 5; i++) begin
      l = l ^ ref_mask(2 * i, 1'b0);
      tog_a(10'b1 << (2 * i), l, i + 1, "scrambled move");
    end

    // Mid-game reset, switches ignored in IDLE, then a press restarts.
    rst = 1'b1;
    exp_a(10'b0000000000, 0, 1'b0, SIdle, 1, "mid reset");
    tick(1);
    rst = 1'b0;
    tick(12);
    sw_a = sw_a ^ 10'b0010000000;
    tick(12);
    fix_a("fix after reset");

    // Wrap-around instance with a 2-bit move counter that saturates.
    btn_fix_b = 1'b0;
    exp_b(Fix, 0, SPlay, "B fix");
    tick(10);
    btn_fix_b = 1'b1;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      sw_b[0] = ~sw_b[0];
      exp_b((i % 2 == 0) ? 10'b1111111101 : Fix, (i < 3) ? i + 1 : 3, SPlay, "B wrap move");
      tick(10);
    end

    tick(20);
    check("pending A", qa_val.size(), 32'd0);
    check("pending B", qb_val.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
